// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS program-counter sequencer with return-address stack
module pc_sequencer #(
    parameter int               XLEN         = 32,
    parameter int               INDEX_W      = 26,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0040_0000,
    parameter logic [XLEN-1:0]  EXC_VECTOR   = 32'h8000_0180,
    parameter int               RAS_DEPTH    = 4,
    localparam int              PTR_W        = $clog2(RAS_DEPTH),
    localparam int              CNT_W        = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               exc,
    input  logic               branch_taken,
    input  logic [15:0]        branch_off,
    input  logic               jump,
    input  logic               link,
    input  logic [INDEX_W-1:0] instr_index,
    input  logic               ret,
    input  logic [XLEN-1:0]    jr_target,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [CNT_W-1:0]   ras_count,
    output logic               ras_miss
);

    logic [XLEN-1:0]  r_pc;
    logic [PTR_W-1:0] r_ptr;      // next free slot; top of stack is r_ptr-1
    logic [CNT_W-1:0] r_count;
    logic             r_miss;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];

    logic [XLEN-1:0]  w_next_pc;
    logic [XLEN-1:0]  w_br_target;
    logic [XLEN-1:0]  w_jmp_target;
    logic [PTR_W-1:0] w_top_idx;
    logic             w_push;
    logic             w_pop;
    logic             w_miss;
    logic             w_ras_full;
    logic             w_ras_empty;

    assign pc_plus4     = r_pc + XLEN'(4);
    assign w_br_target  = pc_plus4 + {{(XLEN-18){branch_off[15]}}, branch_off, 2'b00};
    assign w_jmp_target = {pc_plus4[XLEN-1:INDEX_W+2], instr_index, 2'b00};
    assign w_top_idx    = r_ptr - PTR_W'(1);
    assign w_ras_full   = (r_count == CNT_W'(RAS_DEPTH));
    assign w_ras_empty  = (r_count == '0);

    // Select next PC by priority and decide the single RAS action for this cycle
    always_comb begin
        w_next_pc = pc_plus4;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_miss    = 1'b0;
        if (exc) begin
            w_next_pc = EXC_VECTOR;
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (branch_taken) begin
            w_next_pc = w_br_target;
        end else if (jump) begin
            w_next_pc = w_jmp_target;
            w_push    = link;
        end else if (ret) begin
            if (w_ras_empty) begin
                w_next_pc = jr_target;
                w_miss    = 1'b1;
            end else begin
                w_next_pc = r_ras[w_top_idx];
                w_pop     = 1'b1;
            end
        end
    end

    // PC, stack pointer, occupancy and miss pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_VECTOR;
            r_ptr   <= '0;
            r_count <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_pc   <= w_next_pc;
            r_miss <= w_miss;
            if (w_push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (!w_ras_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Stack storage; a push when full lands on the oldest entry because the pointer wraps
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= pc_plus4;
        end
    end

    assign pc        = r_pc;
    assign ras_count = r_count;
    assign ras_miss  = r_miss;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the single-issue MIPS datapath. Holds the architectural PC register and selects the next PC from sequential, branch, J/JAL pseudo-direct and return targets, plus an exception vector. Generates jump targets as {PC+4 upper bits, instr_index, 2'b00}. Adds a small return-address stack (RAS) so JR $ra resolves without a register-file read when the stack is non-empty.

Parameters:
XLEN, 32, PC width in bits (≥ INDEX_W+4).
INDEX_W, 26, J-type instruction index width.
RESET_VECTOR, 32'h0040_0000, PC value after reset.
EXC_VECTOR, 32'h8000_0180, PC loaded on exception.
RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC this cycle (ignored when exc=1).
exc  in  1  exception: load EXC_VECTOR.
branch_taken  in  1  conditional branch resolved taken.
branch_off  in  16  signed word offset from the branch instruction.
jump  in  1  J/JAL this cycle.
link  in  1  with jump: JAL, push PC+4 onto RAS.
instr_index  in  INDEX_W  J-type target field.
ret  in  1  JR $ra this cycle.
jr_target  in  XLEN  register-file value used when RAS is empty.
pc  out  XLEN  current PC (registered).
pc_plus4  out  XLEN  pc+4, combinational from pc.
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries (registered).
ras_miss  out  1  registered one-cycle pulse: ret taken with RAS empty.

Behaviour:
- Reset (async, active-high): pc=RESET_VECTOR, ras_count=0, ras_miss=0, RAS pointer=0; entries need not be cleared. Deassertion is synchronous to clk; first update on the first rising edge after release.
- next_pc, priority high→low, evaluated each rising edge:
  1. exc → EXC_VECTOR (overrides stall).
  2. stall → pc held; no RAS push/pop; ras_miss=0.
  3. branch_taken → pc_plus4 + (sign_ext(branch_off) << 2), truncated mod 2^XLEN.
  4. jump → {pc_plus4[XLEN-1:INDEX_W+2], instr_index, 2'b00}. If link: push pc_plus4.
  5. ret → RAS non-empty: pop top; empty: jr_target, ras_miss=1 next cycle.
  6. otherwise → pc_plus4.
- Only the winning source acts: lower-priority jump/link/ret inputs are ignored that cycle (no push, no pop).
- exc: no RAS activity; RAS contents and count preserved.
- Latency: one cycle from inputs to updated pc; pc_plus4 follows pc combinationally.
- RAS: circular buffer, top pointer wraps mod RAS_DEPTH. Push on full overwrites oldest entry; ras_count saturates at RAS_DEPTH. Pop on count 0 never changes pointer or count. Pop returns the most recent push (LIFO).
- ras_miss: high exactly one cycle after the missed ret; low otherwise.
- Arithmetic wraps silently at 2^XLEN; no overflow flag.
- pc bits [1:0] are 0 for all internally generated targets; jr_target is passed through unmodified (alignment fault handled elsewhere).

Test Plan:
- Reset release, no controls for 3 cycles → pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; ras_count=0.
- pc=0x00400010, branch_taken, branch_off=16'hFFFC → pc=0x00400004; branch_off=16'h0003 from same pc → 0x00400020.
- pc=0x9000_0000, jump, instr_index=26'h0000100 → pc=0x9000_0400; with link, ras_count=1, later ret → pc=0x9000_0004, ras_count=0.
- Five JALs (RAS_DEPTH=4) then five rets → first four rets return the last four link addresses in reverse order; fifth ret uses jr_target=0x1234_5678, ras_miss pulses once.
- stall held 3 cycles with jump asserted → pc unchanged, ras_count unchanged; exc asserted with stall → pc=0x8000_0180 next cycle.
- Reset asserted mid-sequence asynchronously (between edges) → pc=0x00400000 immediately, ras_count=0, ras_miss=0.
